// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a parallel word out MSB-first, repeating reps+1 times.
// Optional even-parity bit after each word copy: define SERIAL_PATTERN_TX_PARITY_EN.
module serial_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic [CNT_W-1:0] reps,
    output logic             q,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BCW-1:0] LAST = BCW'(WIDTH - 1);

`ifdef SERIAL_PATTERN_TX_PARITY_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        DONE  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd3
    } state_t;
`endif

    state_t           state, state_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic [WIDTH-1:0] hold, hold_n;
    logic [BCW-1:0]   bcnt, bcnt_n;
    logic [CNT_W-1:0] rcnt, rcnt_n;
    logic             q_n, valid_n, busy_n, done_n;
    logic             more;

    assign more = (rcnt != '0);

    always_comb begin
        state_n = state;
        sreg_n  = sreg;
        hold_n  = hold;
        bcnt_n  = bcnt;
        rcnt_n  = rcnt;
        unique case (state)
            IDLE: begin
                if (start) begin
                    sreg_n  = data;
                    hold_n  = data;
                    rcnt_n  = reps;
                    bcnt_n  = LAST;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                sreg_n = {sreg[WIDTH-2:0], 1'b0};
                if (bcnt != '0) begin
                    bcnt_n = bcnt - 1'b1;
                end else begin
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                    state_n = PAR;
`else
                    // Last bit of a copy: reload straight away so copies abut.
                    if (more) begin
                        sreg_n = hold;
                        bcnt_n = LAST;
                        rcnt_n = rcnt - 1'b1;
                    end else begin
                        state_n = DONE;
                    end
`endif
                end
            end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            PAR: begin
                if (more) begin
                    sreg_n  = hold;
                    bcnt_n  = LAST;
                    rcnt_n  = rcnt - 1'b1;
                    state_n = SHIFT;
                end else begin
                    state_n = DONE;
                end
            end
`endif
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Outputs are computed from next state so every port comes from a flop.
    always_comb begin
        q_n     = 1'b0;
        valid_n = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        unique case (state_n)
            SHIFT: begin
                q_n     = sreg_n[WIDTH-1];
                valid_n = 1'b1;
                busy_n  = 1'b1;
            end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            PAR: begin
                q_n     = ^hold_n;
                valid_n = 1'b1;
                busy_n  = 1'b1;
            end
`endif
            DONE: begin
                done_n = 1'b1;
            end
            default: begin
                q_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sreg  <= '0;
            hold  <= '0;
            bcnt  <= '0;
            rcnt  <= '0;
            q     <= 1'b0;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            sreg  <= sreg_n;
            hold  <= hold_n;
            bcnt  <= bcnt_n;
            rcnt  <= rcnt_n;
            q     <= q_n;
            valid <= valid_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Self-checking bench for serial_pattern_tx against a bit-queue reference model.
// Follows SERIAL_PATTERN_TX_PARITY_EN when it is defined for the build.
module tb_serial_pattern_tx;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    localparam int PEN = 1;
`else
    localparam int PEN = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] reps;
    logic             q, valid, busy, done;

    int tests = 0;
    int fails = 0;

    serial_pattern_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .data  (data),
        .reps  (reps),
        .q     (q),
        .valid (valid),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic exp_done);
        chk({tag, ".q"}, 32'(q), 32'd0);
        chk({tag, ".valid"}, 32'(valid), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".done"}, 32'(done), 32'(exp_done));
    endtask

    // Reference: the frame is the word MSB-first, then optional even parity,
    // repeated reps+1 times, then a one-cycle done and a return to idle.
    task automatic send(input logic [WIDTH-1:0] d, input int rp,
                        input bit inject);
        bit exp[$];
        for (int r = 0; r <= rp; r++) begin
            for (int i = WIDTH - 1; i >= 0; i--) exp.push_back(d[i]);
            if (PEN != 0) exp.push_back(bit'($countones(d) % 2));
        end
        start = 1'b1;
        data  = d;
        reps  = CNT_W'(rp);
        @(negedge clk);
        start = 1'b0;
        data  = WIDTH'($urandom);
        reps  = CNT_W'($urandom);
        foreach (exp[i]) begin
            chk($sformatf("bit%0d.q", i), 32'(q), 32'(exp[i]));
            chk($sformatf("bit%0d.valid", i), 32'(valid), 32'd1);
            chk($sformatf("bit%0d.busy", i), 32'(busy), 32'd1);
            chk($sformatf("bit%0d.done", i), 32'(done), 32'd0);
            if (inject && i == 3) begin
                start = 1'b1;
                data  = '1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk_idle("donecyc", 1'b1);
        if (inject) begin
            start = 1'b1;
            data  = '1;
        end
        @(negedge clk);
        chk_idle("idle1", 1'b0);
        start = 1'b0;
        @(negedge clk);
        chk_idle("idle2", 1'b0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        data  = 8'hFF;
        reps  = '0;
        @(negedge clk);
        chk_idle("rst0", 1'b0);
        @(negedge clk);
        chk_idle("rst1", 1'b0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk_idle("postrst", 1'b0);

        send(8'hB4, 0, 1'b0);
        send(8'h81, 2, 1'b0);
        send(8'h07, 0, 1'b0);
        send(8'hB4, 0, 1'b1);
        send(WIDTH'($urandom), (1 << CNT_W) - 1, 1'b0);

        // Abort mid-frame: reset after bit 4 of 8'hB4.
        start = 1'b1;
        data  = 8'hB4;
        reps  = '0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("abort%0d.q", i), 32'(q), 32'(((8'hB4) >> (7 - i)) & 1));
            chk($sformatf("abort%0d.valid", i), 32'(valid), 32'd1);
            if (i < 4) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        chk_idle("abort_rst", 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk_idle($sformatf("abort_quiet%0d", i), 1'b0);
        end
        send(8'hB4, 0, 1'b0);

        for (int n = 0; n < 6; n++)
            send(WIDTH'($urandom), int'($urandom_range(0, 3)), n[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout tests=%0d", tests);
        $fatal(1, "timeout");
    end

endmodule
